// File: rtl/mem_port_arbiter_pkg.sv
// Shared width helpers for the memory port arbiter.
// Widths of the index, outgoing tag and credit counter.
package mem_port_arbiter_pkg;

  // Index bits added to the tag (0 for a single requester).
  function automatic int sel_w(input int n);
    return (n > 1) ? $clog2(n) : 0;
  endfunction

  // Width of an index signal (never zero).
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Outgoing memory tag width.
  function automatic int otag_w(input int tw, input int n);
    return tw + sel_w(n);
  endfunction

  // Width of the outstanding-read counter.
  function automatic int cnt_w(input int max_pend);
    return $clog2(max_pend + 1);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_select.sv
// Round-robin first-one search starting at a pointer.
// Ports: i_req (requests), i_ptr (start index) -> o_gnt (one-hot), o_idx, o_valid.
module rr_select #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_idx,
  output logic          o_valid
);

  always_comb begin
    int w_j;
    o_gnt   = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    w_j     = 0;
    for (int k = 0; k < N; k++) begin
      w_j = int'(i_ptr) + k;
      if (w_j >= N) w_j = w_j - N;
      if (!o_valid && i_req[w_j]) begin
        o_valid    = 1'b1;
        o_gnt[w_j] = 1'b1;
        o_idx      = IW'(w_j);
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port among NUM_REQS requesters (round robin, read credits).
// Ports: in_req_* / in_rsp_* upstream, mem_req_* / mem_rsp_* memory, pending_reads, busy.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int NUM_REQS    = 4,
  parameter int ADDR_WIDTH  = 26,
  parameter int DATA_WIDTH  = 512,
  parameter int TAG_WIDTH   = 8,
  parameter int MAX_PENDING = 16
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [NUM_REQS-1:0]                    in_req_valid,
  input  logic [NUM_REQS-1:0]                    in_req_rw,
  input  logic [NUM_REQS*(DATA_WIDTH/8)-1:0]     in_req_byteen,
  input  logic [NUM_REQS*ADDR_WIDTH-1:0]         in_req_addr,
  input  logic [NUM_REQS*DATA_WIDTH-1:0]         in_req_data,
  input  logic [NUM_REQS*TAG_WIDTH-1:0]          in_req_tag,
  output logic [NUM_REQS-1:0]                    in_req_ready,
  output logic [NUM_REQS-1:0]                    in_rsp_valid,
  output logic [NUM_REQS*DATA_WIDTH-1:0]         in_rsp_data,
  output logic [NUM_REQS*TAG_WIDTH-1:0]          in_rsp_tag,
  input  logic [NUM_REQS-1:0]                    in_rsp_ready,
  output logic                                   mem_req_valid,
  output logic                                   mem_req_rw,
  output logic [DATA_WIDTH/8-1:0]                mem_req_byteen,
  output logic [ADDR_WIDTH-1:0]                  mem_req_addr,
  output logic [DATA_WIDTH-1:0]                  mem_req_data,
  output logic [otag_w(TAG_WIDTH,NUM_REQS)-1:0]  mem_req_tag,
  input  logic                                   mem_req_ready,
  input  logic                                   mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0]                  mem_rsp_data,
  input  logic [otag_w(TAG_WIDTH,NUM_REQS)-1:0]  mem_rsp_tag,
  output logic                                   mem_rsp_ready,
  output logic [cnt_w(MAX_PENDING)-1:0]          pending_reads,
  output logic                                   busy
);

  localparam int SEL_W  = sel_w(NUM_REQS);
  localparam int IDX_W  = idx_w(NUM_REQS);
  localparam int OTAG_W = otag_w(TAG_WIDTH, NUM_REQS);
  localparam int BE_W   = DATA_WIDTH / 8;
  localparam int CNT_W  = cnt_w(MAX_PENDING);

  typedef struct packed {
    logic                  rw;
    logic [BE_W-1:0]       byteen;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
    logic [OTAG_W-1:0]     tag;
  } mem_req_t;

  logic                 r_valid;
  mem_req_t             r_req;
  logic [CNT_W-1:0]     r_pend;
  logic [IDX_W-1:0]     r_ptr;

  logic                 w_slot_free;
  logic                 w_slot_read;
  logic                 w_credit_ok;
  logic [NUM_REQS-1:0]  w_elig;
  logic [NUM_REQS-1:0]  w_gnt;
  logic [IDX_W-1:0]     w_gidx;
  logic                 w_gval;
  logic                 w_fire;
  logic [IDX_W-1:0]     w_ptr_nxt;
  logic [TAG_WIDTH-1:0] w_itag;
  logic [OTAG_W-1:0]    w_otag;
  mem_req_t             w_req;
  logic                 w_inc;
  logic                 w_dec;
  logic [IDX_W-1:0]     w_ridx;

  assign w_slot_free = !r_valid || mem_req_ready;
  assign w_slot_read = r_valid && !r_req.rw;

  // A read parked in the slot already holds a credit.
  assign w_credit_ok =
    (int'(r_pend) + int'(w_slot_read)) < MAX_PENDING;

  always_comb begin
    w_elig = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      w_elig[i] = in_req_valid[i] &&
                  (in_req_rw[i] || w_credit_ok);
    end
  end

  rr_select #(
    .N  (NUM_REQS),
    .IW (IDX_W)
  ) u_rr (
    .i_req   (w_elig),
    .i_ptr   (r_ptr),
    .o_gnt   (w_gnt),
    .o_idx   (w_gidx),
    .o_valid (w_gval)
  );

  assign w_fire       = w_slot_free && w_gval;
  assign in_req_ready = w_slot_free ? w_gnt : '0;

  assign w_ptr_nxt =
    (int'(w_gidx) == NUM_REQS - 1) ? '0 :
    IDX_W'(int'(w_gidx) + 1);

  assign w_itag =
    in_req_tag[int'(w_gidx)*TAG_WIDTH +: TAG_WIDTH];

  generate
    if (SEL_W > 0) begin : g_tag_idx
      assign w_otag = {w_gidx[SEL_W-1:0], w_itag};
      assign w_ridx = mem_rsp_tag[OTAG_W-1 -: SEL_W];
    end else begin : g_tag_pass
      assign w_otag = w_itag;
      assign w_ridx = '0;
    end
  endgenerate

  always_comb begin
    w_req        = '0;
    w_req.rw     = in_req_rw[w_gidx];
    w_req.byteen =
      in_req_byteen[int'(w_gidx)*BE_W +: BE_W];
    w_req.addr   =
      in_req_addr[int'(w_gidx)*ADDR_WIDTH +: ADDR_WIDTH];
    w_req.data   =
      in_req_data[int'(w_gidx)*DATA_WIDTH +: DATA_WIDTH];
    w_req.tag    = w_otag;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_ptr   <= '0;
    end else if (w_fire) begin
      r_valid <= 1'b1;
      r_ptr   <= w_ptr_nxt;
    end else if (mem_req_ready) begin
      r_valid <= 1'b0;
    end
  end

  // Payload needs no reset; it is qualified by r_valid.
  always_ff @(posedge clk) begin
    if (w_fire) r_req <= w_req;
  end

  assign w_inc = r_valid && mem_req_ready && !r_req.rw;
  assign w_dec = mem_rsp_valid && mem_rsp_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pend <= '0;
    end else if (w_inc && !w_dec) begin
      r_pend <= r_pend + 1'b1;
    end else if (w_dec && !w_inc) begin
      r_pend <= r_pend - 1'b1;
    end
  end

  assign mem_req_valid  = r_valid;
  assign mem_req_rw     = r_req.rw;
  assign mem_req_byteen = r_req.byteen;
  assign mem_req_addr   = r_req.addr;
  assign mem_req_data   = r_req.data;
  assign mem_req_tag    = r_req.tag;

  assign mem_rsp_ready =
    (int'(w_ridx) < NUM_REQS) ? in_rsp_ready[w_ridx] : 1'b0;

  always_comb begin
    in_rsp_valid = '0;
    for (int j = 0; j < NUM_REQS; j++) begin
      in_rsp_valid[j] = mem_rsp_valid && (int'(w_ridx) == j);
    end
  end

  assign in_rsp_data = {NUM_REQS{mem_rsp_data}};
  assign in_rsp_tag  = {NUM_REQS{mem_rsp_tag[TAG_WIDTH-1:0]}};

  assign pending_reads = r_pend;
  assign busy          = (r_pend != '0) || r_valid;

  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(mem_rsp_valid && r_pend == '0));
      assert (!(mem_rsp_valid && int'(w_ridx) >= NUM_REQS));
      assert (!(w_inc && !w_dec &&
                int'(r_pend) >= MAX_PENDING));
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and random bench for mem_port_arbiter.
// Reference model tracks slot, pointer, credits and memory queue.
module tb_mem_port_arbiter;

  localparam int N  = 4;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int TW = 8;
  localparam int MP = 6;
  localparam int BW = DW / 8;
  localparam int OW = TW + 2;
  localparam int CW = $clog2(MP + 1);

  logic            clk;
  logic            reset;
  logic [N-1:0]    in_req_valid;
  logic [N-1:0]    in_req_rw;
  logic [N*BW-1:0] in_req_byteen;
  logic [N*AW-1:0] in_req_addr;
  logic [N*DW-1:0] in_req_data;
  logic [N*TW-1:0] in_req_tag;
  logic [N-1:0]    in_req_ready;
  logic [N-1:0]    in_rsp_valid;
  logic [N*DW-1:0] in_rsp_data;
  logic [N*TW-1:0] in_rsp_tag;
  logic [N-1:0]    in_rsp_ready;
  logic            mem_req_valid;
  logic            mem_req_rw;
  logic [BW-1:0]   mem_req_byteen;
  logic [AW-1:0]   mem_req_addr;
  logic [DW-1:0]   mem_req_data;
  logic [OW-1:0]   mem_req_tag;
  logic            mem_req_ready;
  logic            mem_rsp_valid;
  logic [DW-1:0]   mem_rsp_data;
  logic [OW-1:0]   mem_rsp_tag;
  logic            mem_rsp_ready;
  logic [CW-1:0]   pending_reads;
  logic            busy;

  mem_port_arbiter #(
    .NUM_REQS    (N),
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (DW),
    .TAG_WIDTH   (TW),
    .MAX_PENDING (MP)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .in_req_valid   (in_req_valid),
    .in_req_rw      (in_req_rw),
    .in_req_byteen  (in_req_byteen),
    .in_req_addr    (in_req_addr),
    .in_req_data    (in_req_data),
    .in_req_tag     (in_req_tag),
    .in_req_ready   (in_req_ready),
    .in_rsp_valid   (in_rsp_valid),
    .in_rsp_data    (in_rsp_data),
    .in_rsp_tag     (in_rsp_tag),
    .in_rsp_ready   (in_rsp_ready),
    .mem_req_valid  (mem_req_valid),
    .mem_req_rw     (mem_req_rw),
    .mem_req_byteen (mem_req_byteen),
    .mem_req_addr   (mem_req_addr),
    .mem_req_data   (mem_req_data),
    .mem_req_tag    (mem_req_tag),
    .mem_req_ready  (mem_req_ready),
    .mem_rsp_valid  (mem_rsp_valid),
    .mem_rsp_data   (mem_rsp_data),
    .mem_rsp_tag    (mem_rsp_tag),
    .mem_rsp_ready  (mem_rsp_ready),
    .pending_reads  (pending_reads),
    .busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit            m_valid;
  bit            m_rw;
  logic [BW-1:0] m_be;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  logic [OW-1:0] m_tag;
  int            m_pend;
  int            m_ptr;
  logic [OW-1:0] memq[$];

  // Observed values captured at the last sample point
  logic [N-1:0]  o_rdy;
  logic          o_valid;
  logic [CW-1:0] o_pend;
  logic          o_busy;
  logic [N-1:0]  o_irv;
  logic          o_mrr;
  logic [AW-1:0] o_addr;
  logic [OW-1:0] o_tag;

  task automatic chk(input string name,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             name, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input bit rw,
                         input logic [TW-1:0] tag);
    in_req_rw[i]            = rw;
    in_req_tag[i*TW +: TW]  = tag;
    in_req_addr[i*AW +: AW] = AW'($urandom);
    in_req_data[i*DW +: DW] = DW'($urandom);
    in_req_byteen[i*BW +: BW] = BW'($urandom);
  endtask

  task automatic set_rsp(input bit v);
    mem_rsp_valid = v && (memq.size() > 0);
    mem_rsp_tag   = (memq.size() > 0) ? memq[0] : '0;
    mem_rsp_data  = DW'($urandom);
  endtask

  // Sample at negedge, compare to the model, advance the model.
  task automatic step();
    int g;
    int ridx;
    bit free;
    bit credit;
    bit mrr;
    bit inc;
    bit dec;
    @(negedge clk);
    o_rdy   = in_req_ready;
    o_valid = mem_req_valid;
    o_pend  = pending_reads;
    o_busy  = busy;
    o_irv   = in_rsp_valid;
    o_mrr   = mem_rsp_ready;
    o_addr  = mem_req_addr;
    o_tag   = mem_req_tag;
    if (reset) begin
      m_valid = 0;
      m_pend  = 0;
      m_ptr   = 0;
      memq.delete();
    end else begin
      free   = !m_valid || mem_req_ready;
      credit = (m_pend + ((m_valid && !m_rw) ? 1 : 0)) < MP;
      g = -1;
      for (int k = 0; k < N; k++) begin
        int j;
        j = (m_ptr + k) % N;
        if (g < 0 && in_req_valid[j] && (in_req_rw[j] || credit))
          g = j;
      end
      chk("in_req_ready", in_req_ready,
          (free && g >= 0) ? (64'd1 << g) : 64'd0);
      chk("mem_req_valid", mem_req_valid, m_valid);
      if (m_valid) begin
        chk("mem_req_rw", mem_req_rw, m_rw);
        chk("mem_req_addr", mem_req_addr, m_addr);
        chk("mem_req_data", mem_req_data, m_data);
        chk("mem_req_byteen", mem_req_byteen, m_be);
        chk("mem_req_tag", mem_req_tag, m_tag);
      end
      chk("pending_reads", pending_reads, m_pend);
      chk("busy", busy, (m_pend != 0) || m_valid);
      ridx = int'(mem_rsp_tag[OW-1 -: 2]);
      mrr  = in_rsp_ready[ridx];
      chk("in_rsp_valid", in_rsp_valid,
          mem_rsp_valid ? (64'd1 << ridx) : 64'd0);
      chk("mem_rsp_ready", mem_rsp_ready, mrr);
      if (mem_rsp_valid) begin
        chk("in_rsp_tag", in_rsp_tag[ridx*TW +: TW],
            mem_rsp_tag[TW-1:0]);
        chk("in_rsp_data", in_rsp_data[ridx*DW +: DW],
            mem_rsp_data);
      end
      inc = m_valid && mem_req_ready && !m_rw;
      dec = mem_rsp_valid && mrr;
      if (inc) memq.push_back(m_tag);
      if (dec) void'(memq.pop_front());
      m_pend = m_pend + (inc ? 1 : 0) - (dec ? 1 : 0);
      if (free && g >= 0) begin
        m_valid = 1;
        m_rw    = in_req_rw[g];
        m_be    = in_req_byteen[g*BW +: BW];
        m_addr  = in_req_addr[g*AW +: AW];
        m_data  = in_req_data[g*DW +: DW];
        m_tag   = {2'(g), in_req_tag[g*TW +: TW]};
        m_ptr   = (g + 1) % N;
      end else if (mem_req_ready) begin
        m_valid = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Let memory answer every outstanding read, bounded.
  task automatic drain();
    int n;
    n = 0;
    in_req_valid = '0;
    mem_req_ready = 1'b1;
    in_rsp_ready = '1;
    while ((memq.size() > 0 || m_valid) && n < 200) begin
      set_rsp(1);
      step();
      n++;
    end
    mem_rsp_valid = 1'b0;
    step();
    chk("drain_pending", pending_reads, 0);
  endtask

  logic [AW-1:0] saved_addr;

  initial begin
    reset         = 1'b1;
    in_req_valid  = '0;
    in_req_rw     = '0;
    in_req_byteen = '0;
    in_req_addr   = '0;
    in_req_data   = '0;
    in_req_tag    = '0;
    in_rsp_ready  = '0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;
    mem_rsp_tag   = '0;
    m_valid = 0; m_rw = 0; m_pend = 0; m_ptr = 0;
    m_be = '0; m_addr = '0; m_data = '0; m_tag = '0;
    @(posedge clk); #1;
    step();
    step();
    reset = 1'b0;

    // Reset state
    step();
    chk("rst_valid", o_valid, 0);
    chk("rst_pend", o_pend, 0);
    chk("rst_busy", o_busy, 0);

    // Four readers: grants 0,1,2,3,0, tag appears one cycle later
    for (int i = 0; i < N; i++) set_req(i, 1'b0, TW'(8'h10 + i));
    in_req_valid  = 4'hF;
    mem_req_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (c == 5) in_req_valid = '0;
      step();
      if (c < 5) chk("rr_grant", o_rdy, 64'd1 << (c % 4));
      if (c >= 1) begin
        int r;
        r = (c - 1) % 4;
        chk("rr_tag", o_tag, (r << 8) | (8'h10 + r));
      end
    end
    drain();

    // Credit limit: requester 1 reads, no responses
    set_req(1, 1'b0, 8'h21);
    in_req_valid  = 4'b0010;
    mem_req_ready = 1'b1;
    for (int c = 0; c < 8; c++) step();
    chk("lim_pend", o_pend, MP);
    chk("lim_stall", o_rdy, 0);
    set_req(2, 1'b1, 8'h32);
    in_req_valid = 4'b0110;
    step();
    chk("lim_write", o_rdy, 4'b0100);
    in_req_valid = 4'b0010;
    in_rsp_ready = '1;
    set_rsp(1);
    step();
    chk("lim_same_cyc", o_rdy, 0);
    mem_rsp_valid = 1'b0;
    step();
    chk("lim_release", o_rdy, 4'b0010);
    drain();

    // Response back-pressure on requester 3
    set_req(3, 1'b0, 8'hA5);
    in_req_valid = 4'b1000;
    step();
    in_req_valid = '0;
    step();
    in_rsp_ready = 4'b0111;
    set_rsp(1);
    chk("bp_tag", mem_rsp_tag, 10'h3A5);
    for (int c = 0; c < 2; c++) begin
      step();
      chk("bp_valid", o_irv, 4'b1000);
      chk("bp_ready", o_mrr, 0);
      chk("bp_pend", o_pend, 1);
    end
    in_rsp_ready = 4'b1000;
    step();
    chk("bp_accept", o_mrr, 1);
    mem_rsp_valid = 1'b0;
    step();
    chk("bp_dec", o_pend, 0);

    // Fill to five reads, then fire and respond together
    set_req(0, 1'b0, 8'h05);
    for (int c = 0; c < 20; c++) begin
      if (m_pend == 5 && !m_valid) break;
      in_req_valid[0] =
        (m_pend + ((m_valid && !m_rw) ? 1 : 0)) < 5;
      step();
    end
    in_req_valid  = 4'b0001;
    mem_req_ready = 1'b0;
    step();
    in_req_valid  = '0;
    mem_req_ready = 1'b1;
    in_rsp_ready  = '1;
    set_rsp(1);
    step();
    chk("same_pre", o_pend, 5);
    mem_rsp_valid = 1'b0;
    step();
    chk("same_post", o_pend, 5);

    // Memory stall with requester 0 holding a write
    set_req(0, 1'b1, 8'h0C);
    saved_addr    = in_req_addr[AW-1:0];
    in_req_valid  = 4'b0001;
    mem_req_ready = 1'b0;
    step();
    chk("stall_grant", o_rdy, 4'b0001);
    set_req(0, 1'b1, 8'h0D);
    for (int c = 0; c < 4; c++) begin
      step();
      chk("stall_valid", o_valid, 1);
      chk("stall_rdy", o_rdy, 0);
      chk("stall_addr", o_addr, saved_addr);
    end
    in_req_valid  = '0;
    mem_req_ready = 1'b1;
    step();
    drain();

    // Reset with a full slot and three pending reads
    set_req(2, 1'b0, 8'h77);
    for (int c = 0; c < 20; c++) begin
      if (m_pend == 3 && !m_valid) break;
      in_req_valid[2] =
        (m_pend + ((m_valid && !m_rw) ? 1 : 0)) < 3;
      step();
    end
    in_req_valid  = 4'b0100;
    mem_req_ready = 1'b0;
    step();
    in_req_valid = '0;
    step();
    chk("pre_rst_pend", o_pend, 3);
    chk("pre_rst_valid", o_valid, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    chk("mid_rst_valid", o_valid, 0);
    chk("mid_rst_pend", o_pend, 0);
    chk("mid_rst_busy", o_busy, 0);
    for (int i = 0; i < N; i++) set_req(i, 1'b1, TW'(i));
    in_req_valid  = 4'hF;
    mem_req_ready = 1'b1;
    step();
    chk("mid_rst_ptr", o_rdy, 4'b0001);
    in_req_valid = '0;
    step();
    drain();

    // Random traffic against the model
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++)
        set_req(i, 1'($urandom_range(0, 1)), TW'($urandom));
      in_req_valid  = N'($urandom);
      mem_req_ready = ($urandom_range(0, 3) != 0);
      in_rsp_ready  = N'($urandom);
      set_rsp(1'($urandom_range(0, 1)));
      step();
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
